// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: latches capture configuration, emits control pulses and streams
// ID (and, with `define SUMP_METADATA_EN, metadata) responses to the UART transmitter.
module sump_cmd_decoder #(
  parameter int DATA_BITS       = 8,
  parameter int CMD_WIDTH_WORDS = 5,
  parameter int TRIG_STAGES     = 4,
  parameter int MEM_DEPTH       = 4096
) (
  input  logic                                 clk_i,
  input  logic                                 rst_in,
  input  logic [DATA_BITS*CMD_WIDTH_WORDS-1:0] cmd_i,
  input  logic                                 cmd_stb_i,
  output logic                                 soft_rst_o,
  output logic                                 arm_o,
  output logic [32*TRIG_STAGES-1:0]            trig_mask_o,
  output logic [32*TRIG_STAGES-1:0]            trig_val_o,
  output logic [32*TRIG_STAGES-1:0]            trig_cfg_o,
  output logic [23:0]                          div_o,
  output logic [15:0]                          read_cnt_o,
  output logic [15:0]                          delay_cnt_o,
  output logic [31:0]                          flags_o,
  output logic [7:0]                           tx_data_o,
  output logic                                 tx_valid_o,
  input  logic                                 tx_ready_i,
  output logic                                 tx_busy_o
);

  localparam int CMD_W = DATA_BITS * CMD_WIDTH_WORDS;
  localparam logic [31:0] MEM_DEPTH_W = 32'(MEM_DEPTH);
  localparam logic [3:0] ID_LAST   = 4'd3;
  localparam logic [3:0] META_LAST = 4'd12;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

  tx_state_t  state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       meta_q, meta_d;

  logic [7:0]  long_op;
  logic [7:0]  short_op;
  logic [31:0] param;
  logic        is_long;
  logic        is_short;
  logic [1:0]  stage;
  logic        wr_mask;
  logic        wr_val;
  logic        wr_cfg;
  logic        wr_div;
  logic        wr_cnt;
  logic        wr_flags;
  logic        soft_rst_req;
  logic        arm_req;
  logic        id_req;
  logic        meta_req;
  logic [3:0]  last_idx;

  // Long commands carry the opcode in the first received byte, short ones in the last.
  assign long_op  = cmd_i[7:0];
  assign short_op = cmd_i[CMD_W-1 -: 8];
  assign param    = cmd_i[39:8];
  assign is_long  = cmd_stb_i && cmd_i[7];
  assign is_short = cmd_stb_i && !cmd_i[7];
  assign stage    = long_op[3:2];

  assign wr_mask  = is_long && (long_op[7:4] == 4'hC) && (long_op[1:0] == 2'd0);
  assign wr_val   = is_long && (long_op[7:4] == 4'hC) && (long_op[1:0] == 2'd1);
  assign wr_cfg   = is_long && (long_op[7:4] == 4'hC) && (long_op[1:0] == 2'd2);
  assign wr_div   = is_long && (long_op == 8'h80);
  assign wr_cnt   = is_long && (long_op == 8'h81);
  assign wr_flags = is_long && (long_op == 8'h82);

  // XON/XOFF (0x11/0x13) and unknown short opcodes simply match nothing here.
  assign soft_rst_req = is_short && (short_op == 8'h00);
  assign arm_req      = is_short && (short_op == 8'h01);
  assign id_req       = is_short && (short_op == 8'h02);
`ifdef SUMP_METADATA_EN
  assign meta_req     = is_short && (short_op == 8'h04);
`else
  assign meta_req     = 1'b0;
`endif

  function automatic logic [7:0] id_byte(input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = 8'h31;
      2'd1:    b = 8'h41;
      2'd2:    b = 8'h4C;
      default: b = 8'h53;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] meta_byte(input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = 8'h01;
      4'd1:    b = 8'h6C;
      4'd2:    b = 8'h6F;
      4'd3:    b = 8'h67;
      4'd4:    b = 8'h49;
      4'd5:    b = 8'h50;
      4'd6:    b = 8'h00;
      4'd7:    b = 8'h21;
      4'd8:    b = MEM_DEPTH_W[31:24];
      4'd9:    b = MEM_DEPTH_W[23:16];
      4'd10:   b = MEM_DEPTH_W[15:8];
      4'd11:   b = MEM_DEPTH_W[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Configuration writes and pulses execute regardless of what the TX side is doing.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      soft_rst_o  <= 1'b0;
      arm_o       <= 1'b0;
      trig_mask_o <= '0;
      trig_val_o  <= '0;
      trig_cfg_o  <= '0;
      div_o       <= '0;
      read_cnt_o  <= '0;
      delay_cnt_o <= '0;
      flags_o     <= '0;
    end else begin
      soft_rst_o <= soft_rst_req;
      arm_o      <= arm_req;
      for (int k = 0; k < TRIG_STAGES; k++) begin
        if (int'(stage) == k) begin
          if (wr_mask) trig_mask_o[32*k +: 32] <= param;
          if (wr_val)  trig_val_o[32*k +: 32]  <= param;
          if (wr_cfg)  trig_cfg_o[32*k +: 32]  <= param;
        end
      end
      if (wr_div) div_o <= param[23:0];
      if (wr_cnt) begin
        read_cnt_o  <= param[15:0];
        delay_cnt_o <= param[31:16];
      end
      if (wr_flags) flags_o <= param;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      meta_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      meta_q  <= meta_d;
    end
  end

  assign last_idx = meta_q ? META_LAST : ID_LAST;

  // Requests arriving in SEND are dropped; a soft reset aborts the response.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    meta_d  = meta_q;
    if (soft_rst_req) begin
      state_d = IDLE;
      idx_d   = '0;
      meta_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (id_req) begin
            state_d = SEND;
            idx_d   = '0;
            meta_d  = 1'b0;
          end else if (meta_req) begin
            state_d = SEND;
            idx_d   = '0;
            meta_d  = 1'b1;
          end
        end
        SEND: begin
          if (tx_ready_i) begin
            if (idx_q == last_idx) begin
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    tx_valid_o = (state_q == SEND);
    tx_busy_o  = (state_q == SEND);
`ifdef SUMP_METADATA_EN
    tx_data_o  = meta_q ? meta_byte(idx_q) : id_byte(idx_q[1:0]);
`else
    tx_data_o  = id_byte(idx_q[1:0]);
`endif
  end

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: register decode, pulses and scoreboarded TX byte streams.
module tb_sump_cmd_decoder;

  localparam int STAGES = 2;
  localparam int TW     = 32 * STAGES;

  logic          clk_i = 1'b0;
  logic          rst_in;
  logic [39:0]   cmd_i;
  logic          cmd_stb_i;
  logic          soft_rst_o;
  logic          arm_o;
  logic [TW-1:0] trig_mask_o;
  logic [TW-1:0] trig_val_o;
  logic [TW-1:0] trig_cfg_o;
  logic [23:0]   div_o;
  logic [15:0]   read_cnt_o;
  logic [15:0]   delay_cnt_o;
  logic [31:0]   flags_o;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic          tx_busy_o;

  sump_cmd_decoder #(.TRIG_STAGES(STAGES)) dut (
    .clk_i       (clk_i),
    .rst_in      (rst_in),
    .cmd_i       (cmd_i),
    .cmd_stb_i   (cmd_stb_i),
    .soft_rst_o  (soft_rst_o),
    .arm_o       (arm_o),
    .trig_mask_o (trig_mask_o),
    .trig_val_o  (trig_val_o),
    .trig_cfg_o  (trig_cfg_o),
    .div_o       (div_o),
    .read_cnt_o  (read_cnt_o),
    .delay_cnt_o (delay_cnt_o),
    .flags_o     (flags_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .tx_busy_o   (tx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int         check_cnt = 0;
  int         error_cnt = 0;
  int         cyc       = 0;
  int         acc_cnt   = 0;
  int         extra_cnt = 0;
  bit         ready_en  = 1'b0;
  logic [7:0] exp_q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte monitor: every accepted byte is popped from the scoreboard; held bytes must not change.
  always @(negedge clk_i) begin
    if (prev_hold && tx_valid_o) checkOutput("tx_hold", tx_data_o, prev_data);
    if (tx_valid_o && tx_ready_i) begin
      acc_cnt++;
      if (exp_q.size() > 0) checkOutput("tx_byte", tx_data_o, exp_q.pop_front());
      else extra_cnt++;
    end
    prev_hold = tx_valid_o && !tx_ready_i;
    prev_data = tx_data_o;
  end

  function automatic logic [39:0] long_cmd(input logic [7:0] op, input logic [31:0] p);
    return {p, op};
  endfunction

  function automatic logic [39:0] short_cmd(input logic [7:0] op);
    return {op, 32'h5A5A_5A12};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    cmd_stb_i  = 1'b0;
    tx_ready_i = ready_en && (cyc % 3 == 0);
  endtask

  task automatic applyStimulus(input logic [39:0] cmd);
    cmd_i     = cmd;
    cmd_stb_i = 1'b1;
    tick();
  endtask

  task automatic pushId();
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'h53);
  endtask

  task automatic waitAccepts(input int n);
    int budget = 200;
    while (acc_cnt < n && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput("accept_wait", acc_cnt >= n, 1'b1);
  endtask

  task automatic drain(input string tag);
    int budget = 300;
    while ((exp_q.size() != 0 || tx_busy_o) && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput(tag, exp_q.size(), 0);
    checkOutput("busy_after_last", tx_busy_o, 1'b0);
    checkOutput("valid_after_last", tx_valid_o, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_div"}, div_o, 24'h0);
    checkOutput({tag, "_rcnt"}, read_cnt_o, 16'h0);
    checkOutput({tag, "_dcnt"}, delay_cnt_o, 16'h0);
    checkOutput({tag, "_flags"}, flags_o, 32'h0);
    checkOutput({tag, "_mask"}, trig_mask_o, '0);
    checkOutput({tag, "_val"}, trig_val_o, '0);
    checkOutput({tag, "_cfg"}, trig_cfg_o, '0);
    checkOutput({tag, "_valid"}, tx_valid_o, 1'b0);
    checkOutput({tag, "_busy"}, tx_busy_o, 1'b0);
    checkOutput({tag, "_srst"}, soft_rst_o, 1'b0);
    checkOutput({tag, "_arm"}, arm_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_in     = 1'b0;
    cmd_i      = '0;
    cmd_stb_i  = 1'b0;
    tx_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkResetValues("rst");
    rst_in = 1'b1;
    tick();

    applyStimulus(long_cmd(8'h80, 32'hAB12_3456));
    checkOutput("div", div_o, 24'h12_3456);

    applyStimulus(long_cmd(8'hC4, 32'hDEAD_BEEF));
    checkOutput("mask_s1", trig_mask_o, {32'hDEAD_BEEF, 32'h0});
    applyStimulus(long_cmd(8'hC1, 32'h1122_3344));
    checkOutput("val_s0", trig_val_o, {32'h0, 32'h1122_3344});
    applyStimulus(long_cmd(8'hC6, 32'h5566_7788));
    checkOutput("cfg_s1", trig_cfg_o, {32'h5566_7788, 32'h0});

    // Stage 3 and 2 do not exist with two stages; opcode C3 is not a trigger register.
    applyStimulus(long_cmd(8'hCC, 32'hFFFF_FFFF));
    applyStimulus(long_cmd(8'hCD, 32'hFFFF_FFFF));
    applyStimulus(long_cmd(8'hCA, 32'hFFFF_FFFF));
    applyStimulus(long_cmd(8'hC3, 32'hFFFF_FFFF));
    checkOutput("mask_oob", trig_mask_o, {32'hDEAD_BEEF, 32'h0});
    checkOutput("val_oob", trig_val_o, {32'h0, 32'h1122_3344});
    checkOutput("cfg_oob", trig_cfg_o, {32'h5566_7788, 32'h0});

    applyStimulus(long_cmd(8'h82, 32'hCAFE_F00D));
    checkOutput("flags", flags_o, 32'hCAFE_F00D);
    applyStimulus(long_cmd(8'h83, 32'h1234_5678));
    checkOutput("unk_long_flags", flags_o, 32'hCAFE_F00D);
    checkOutput("unk_long_div", div_o, 24'h12_3456);

    applyStimulus(short_cmd(8'h11));
    applyStimulus(short_cmd(8'h13));
    checkOutput("xoff_srst", soft_rst_o, 1'b0);
    checkOutput("xoff_arm", arm_o, 1'b0);
    checkOutput("xoff_valid", tx_valid_o, 1'b0);

    $display("[TB] ID response, ready every third cycle");
    ready_en = 1'b1;
    acc_cnt  = 0;
    pushId();
    applyStimulus(short_cmd(8'h02));
    drain("id_drain");
    checkOutput("id_count", acc_cnt, 4);

    $display("[TB] ID response with overlapping requests");
    acc_cnt   = 0;
    extra_cnt = 0;
    pushId();
    applyStimulus(short_cmd(8'h02));
    tick();
    applyStimulus(short_cmd(8'h02));
    applyStimulus(long_cmd(8'h81, 32'h0010_0020));
    checkOutput("rcnt_busy", read_cnt_o, 16'h0020);
    checkOutput("dcnt_busy", delay_cnt_o, 16'h0010);
    drain("id2_drain");
    repeat (6) tick();
    checkOutput("id2_count", acc_cnt, 4);
    checkOutput("id2_extra", extra_cnt, 0);

    $display("[TB] soft reset during ID response");
    acc_cnt = 0;
    pushId();
    applyStimulus(short_cmd(8'h02));
    waitAccepts(2);
    ready_en   = 1'b0;
    tx_ready_i = 1'b0;
    applyStimulus(short_cmd(8'h00));
    checkOutput("srst_pulse", soft_rst_o, 1'b1);
    checkOutput("srst_valid", tx_valid_o, 1'b0);
    checkOutput("srst_busy", tx_busy_o, 1'b0);
    checkOutput("srst_div_kept", div_o, 24'h12_3456);
    checkOutput("srst_mask_kept", trig_mask_o, {32'hDEAD_BEEF, 32'h0});
    exp_q.delete();
    tick();
    checkOutput("srst_pulse_end", soft_rst_o, 1'b0);
    ready_en  = 1'b1;
    extra_cnt = 0;
    repeat (4) tick();
    checkOutput("srst_idle_valid", tx_valid_o, 1'b0);
    checkOutput("srst_extra", extra_cnt, 0);

    acc_cnt = 0;
    pushId();
    applyStimulus(short_cmd(8'h02));
    drain("id3_drain");
    checkOutput("id3_count", acc_cnt, 4);

    applyStimulus(short_cmd(8'h01));
    checkOutput("arm_pulse", arm_o, 1'b1);
    checkOutput("arm_no_srst", soft_rst_o, 1'b0);
    tick();
    checkOutput("arm_pulse_end", arm_o, 1'b0);

    // Back-to-back strobes, each decoded on its own.
    applyStimulus(long_cmd(8'h80, 32'h0011_1111));
    applyStimulus(long_cmd(8'h82, 32'h2222_2222));
    checkOutput("b2b_div", div_o, 24'h11_1111);
    checkOutput("b2b_flags", flags_o, 32'h2222_2222);

`ifdef SUMP_METADATA_EN
    $display("[TB] metadata response");
    acc_cnt = 0;
    begin
      logic [7:0] meta [13] = '{8'h01, 8'h6C, 8'h6F, 8'h67, 8'h49, 8'h50, 8'h00,
                                8'h21, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
      for (int i = 0; i < 13; i++) exp_q.push_back(meta[i]);
    end
    applyStimulus(short_cmd(8'h04));
    drain("meta_drain");
    checkOutput("meta_count", acc_cnt, 13);
`else
    $display("[TB] metadata request ignored");
    acc_cnt = 0;
    applyStimulus(short_cmd(8'h04));
    checkOutput("meta_off_valid", tx_valid_o, 1'b0);
    checkOutput("meta_off_busy", tx_busy_o, 1'b0);
    repeat (5) tick();
    checkOutput("meta_off_count", acc_cnt, 0);
`endif

    $display("[TB] asynchronous reset mid-sequence");
    acc_cnt = 0;
    pushId();
    applyStimulus(short_cmd(8'h02));
    waitAccepts(1);
    rst_in = 1'b0;
    #1;
    checkResetValues("midrst");
    exp_q.delete();
    tick();
    rst_in = 1'b1;
    repeat (3) tick();
    checkOutput("post_rst_valid", tx_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule

// File: doc/sump_cmd_decoder.md
Name: sump_cmd_decoder

Overview:
- Consumes complete SUMP commands from the UART receiver (`cmd_i`/`cmd_stb_i`).
- Decodes short and long commands and latches the capture configuration registers: trigger stages, divider, read/delay counts, flags.
- Emits single-cycle control pulses (soft reset, arm).
- Answers the ID query by streaming bytes to the UART transmitter over a valid/ready handshake.

Parameters:
- `DATA_BITS`, 8, bits per UART word.
- `CMD_WIDTH_WORDS`, 5, words per long command; `cmd_i` is `DATA_BITS*CMD_WIDTH_WORDS` wide.
- `TRIG_STAGES`, 4, number of trigger stages (1..4).
- `MEM_DEPTH`, 4096, sample memory depth in samples; reported only by the metadata feature.

Ports:
- `clk_i` in 1: system clock.
- `rst_in` in 1: asynchronous reset, active-low.
- `cmd_i` in 40: received command, layout below.
- `cmd_stb_i` in 1: one-cycle strobe, `cmd_i` valid.
- `soft_rst_o` out 1: one-cycle pulse on opcode 0x00.
- `arm_o` out 1: one-cycle pulse on opcode 0x01.
- `trig_mask_o` out `32*TRIG_STAGES`: stage s at [32s+31:32s].
- `trig_val_o` out `32*TRIG_STAGES`: trigger values, same layout.
- `trig_cfg_o` out `32*TRIG_STAGES`: trigger configs, same layout.
- `div_o` out 24: sample clock divider.
- `read_cnt_o` out 16: read count.
- `delay_cnt_o` out 16: delay count.
- `flags_o` out 32: flags word.
- `tx_data_o` out 8: byte to the UART transmitter.
- `tx_valid_o` out 1: `tx_data_o` valid.
- `tx_ready_i` in 1: transmitter accepts the byte.
- `tx_busy_o` out 1: response sequence in progress.

Behaviour:
- Reset (async, `rst_in`=0): every output register is 0; FSM is IDLE; `tx_valid_o`=0.
- Command format, sampled only when `cmd_stb_i`=1:
  - `cmd_i[7]`=1 → long command. Opcode is `cmd_i[7:0]`; parameter P=`cmd_i[39:8]`, little-endian (param byte 1 in [15:8], byte 4 in [39:32]).
  - `cmd_i[7]`=0 → short command. Opcode is `cmd_i[39:32]`; the remaining bits are ignored.
- Latency: register writes and pulses become visible on the cycle after the strobe (1 clk).
- Long opcodes; let s=op[3:2]:
  - 0xC0/C4/C8/CC: `trig_mask` stage s ← P.
  - 0xC1/C5/C9/CD: `trig_val` stage s ← P.
  - 0xC2/C6/CA/CE: `trig_cfg` stage s ← P.
  - If s ≥ `TRIG_STAGES`, the write is ignored.
  - 0x80: `div_o` ← P[23:0]; P[31:24] ignored.
  - 0x81: `read_cnt_o` ← P[15:0]; `delay_cnt_o` ← P[31:16].
  - 0x82: `flags_o` ← P.
  - Any other long opcode: no effect.
- Short opcodes:
  - 0x00: `soft_rst_o` pulse. Configuration registers are NOT cleared; only the TX FSM aborts to IDLE.
  - 0x01: `arm_o` pulse.
  - 0x02: start ID response.
  - 0x11, 0x13 (XON/XOFF): accepted, no effect.
  - Others: ignored.
- TX FSM:
  - States: IDLE → SEND → IDLE.
  - In SEND, `tx_valid_o`=1 and `tx_data_o`=ROM[idx].
  - When `tx_valid_o` && `tx_ready_i`: idx increments; after the last byte the FSM returns to IDLE and `tx_valid_o` drops in the next cycle.
  - `tx_data_o` stays stable while `tx_valid_o`=1 and `tx_ready_i`=0.
  - ID ROM: 0x31, 0x41, 0x4C, 0x53 ("1ALS"), 4 bytes.
  - `tx_busy_o`=1 in SEND.
- Simultaneous or overlapping events:
  - A response request while `tx_busy_o`=1 is dropped; the current sequence continues unaffected.
  - Register-write commands and pulses are always executed, regardless of TX state.
  - `soft_rst_o` during SEND: `tx_valid_o`=0 the next cycle, idx=0, FSM IDLE.
- `cmd_stb_i` in consecutive cycles: each strobe is decoded independently; there is no buffering.
- `rst_in` mid-sequence: immediate return to reset values.

Optional Feature:
- Macro `SUMP_METADATA_EN`.
- Defined: short opcode 0x04 starts a metadata response using the same TX FSM and handshake. Byte sequence, 13 bytes:
  - 0x01, 'l', 'o', 'g', 'I', 'P', 0x00
  - 0x21, then `MEM_DEPTH` as 32-bit big-endian
  - 0x00
- A metadata request while busy is dropped, as for ID.
- Not defined: 0x04 is ignored and no metadata ROM is synthesized.

Test Plan:
- Reset → all config outputs 0, `tx_valid_o`=0, `tx_busy_o`=0. Then strobe long 0x80 with P=0xAB123456 → `div_o`=0x123456 one clk after the strobe.
- Strobe long 0xC4, P=0xDEADBEEF → `trig_mask_o[63:32]`=0xDEADBEEF, other stages unchanged. With `TRIG_STAGES`=2, 0xCC → no change.
- Strobe short 0x02, `tx_ready_i` high every 3rd cycle → bytes 0x31, 0x41, 0x4C, 0x53 in order; each held stable until accepted; `tx_busy_o` low after the 4th accept.
- During ID send, strobe 0x02 again plus long 0x81 with P=0x00100020 → sequence uninterrupted and only 4 bytes sent; `read_cnt_o`=0x0020, `delay_cnt_o`=0x0010.
- During ID send (after byte 2), strobe short 0x00 → `soft_rst_o` one-cycle pulse; `tx_valid_o`=0 next cycle; `div_o` retains its value. Strobe 0x01 → `arm_o` one-cycle pulse.
- With `SUMP_METADATA_EN`, `MEM_DEPTH`=4096: strobe 0x04 → 13 bytes ending in 0x21, 0x00, 0x00, 0x10, 0x00, 0x00. Without the macro → no `tx_valid_o`.
